// File: rtl/pifo_sched_ctrl.sv
// Sequencer in front of a single PIFO: round-robin insert arbitration across enqueue
// ports, one dequeue requester, strict one-op-at-a-time issue with a settle gap.
module pifo_sched_ctrl #(
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned RANK_WIDTH    = 10,
  parameter int unsigned META_WIDTH    = 20,
  parameter int unsigned MAX_ENTRIES   = 160,
  parameter int unsigned L2_OCC        = 8,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS*RANK_WIDTH-1:0]  req_rank,
  input  logic [NUM_PORTS*META_WIDTH-1:0]  req_meta,
  input  logic                             deq_req,
  output logic                             deq_valid,
  output logic [RANK_WIDTH-1:0]            deq_rank,
  output logic [META_WIDTH-1:0]            deq_meta,
  output logic                             pifo_insert,
  output logic                             pifo_remove,
  output logic [RANK_WIDTH-1:0]            pifo_rank_in,
  output logic [META_WIDTH-1:0]            pifo_meta_in,
  input  logic [RANK_WIDTH-1:0]            pifo_rank_out,
  input  logic [META_WIDTH-1:0]            pifo_meta_out,
  input  logic                             pifo_valid_out,
  input  logic                             pifo_busy,
  output logic [L2_OCC-1:0]                occupancy
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [L2_OCC-1:0] OCC_MAX  = L2_OCC'(MAX_ENTRIES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE_INS, ISSUE_REM, SETTLE} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand_idx;
  logic             gnt_found;
  logic             prio_ins;
  logic [CNT_W-1:0] settle_cnt;
  logic             rem_ok;
  logic             ins_ok;
  logic             take_rem;
  logic             take_ins;

  // Round-robin search starting at the port just after the last winner.
  always_comb begin
    gnt_idx   = rr_ptr;
    cand_idx  = '0;
    gnt_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand_idx = PTR_W'((32'(rr_ptr) + k) % NUM_PORTS);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // IDLE decision; prio_ins breaks the tie when both ops are possible.
  always_comb begin
    rem_ok    = deq_req && pifo_valid_out && (occupancy != '0);
    ins_ok    = gnt_found && !pifo_busy && (occupancy < OCC_MAX);
    take_rem  = !rst && (state == IDLE) && rem_ok && (!ins_ok || !prio_ins);
    take_ins  = !rst && (state == IDLE) && ins_ok && !take_rem;
    req_ready = take_ins ? (NUM_PORTS'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= PTR_W'(NUM_PORTS - 1);
      prio_ins     <= 1'b0;
      settle_cnt   <= '0;
      occupancy    <= '0;
      pifo_insert  <= 1'b0;
      pifo_remove  <= 1'b0;
      pifo_rank_in <= '0;
      pifo_meta_in <= '0;
      deq_valid    <= 1'b0;
      deq_rank     <= '0;
      deq_meta     <= '0;
    end else begin
      pifo_insert  <= 1'b0;
      pifo_remove  <= 1'b0;
      pifo_rank_in <= '0;
      pifo_meta_in <= '0;
      deq_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (take_ins) begin
            state        <= ISSUE_INS;
            pifo_insert  <= 1'b1;
            pifo_rank_in <= req_rank[gnt_idx*RANK_WIDTH +: RANK_WIDTH];
            pifo_meta_in <= req_meta[gnt_idx*META_WIDTH +: META_WIDTH];
            rr_ptr       <= gnt_idx;
            occupancy    <= occupancy + L2_OCC'(1);
            if (rem_ok) prio_ins <= ~prio_ins;
          end else if (take_rem) begin
            state       <= ISSUE_REM;
            pifo_remove <= 1'b1;
            occupancy   <= occupancy - L2_OCC'(1);
            if (ins_ok) prio_ins <= ~prio_ins;
          end
        end
        ISSUE_INS: begin
          state      <= SETTLE;
          settle_cnt <= '0;
        end
        ISSUE_REM: begin
          deq_valid  <= 1'b1;
          deq_rank   <= pifo_rank_out;
          deq_meta   <= pifo_meta_out;
          state      <= SETTLE;
          settle_cnt <= '0;
        end
        SETTLE: begin
          if (settle_cnt == CNT_LAST) state <= IDLE;
          else settle_cnt <= settle_cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Simulation-only guards: ops are exclusive and occupancy never exceeds capacity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(pifo_insert && pifo_remove));
      assert (occupancy <= OCC_MAX);
    end
  end

endmodule
